// File: rtl/ptcalc_in_sync.sv
// Input synchroniser for the pT-calculator core: assembles one candidate plus up to
// three segment words arriving on different cycles and issues them under ap_ctrl_hs.
module ptcalc_in_sync #(
    parameter int PL_W    = 64,
    parameter int SF_W    = 32,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic [PL_W-1:0]  pl_in,
    input  logic             pl_in_vld,
    input  logic [SF_W-1:0]  sf_inn_in,
    input  logic [SF_W-1:0]  sf_mid_in,
    input  logic [SF_W-1:0]  sf_out_in,
    input  logic             sf_inn_vld,
    input  logic             sf_mid_vld,
    input  logic             sf_out_vld,
    output logic             ap_start,
    input  logic             ap_ready,
    output logic [PL_W-1:0]  pl2ptcalc,
    output logic [SF_W-1:0]  sf2ptcalc_inn,
    output logic [SF_W-1:0]  sf2ptcalc_mid,
    output logic [SF_W-1:0]  sf2ptcalc_out,
    output logic             busy,
    output logic [CNT_W-1:0] cnt_pl_drop,
    output logic [CNT_W-1:0] cnt_sf_orphan,
    output logic [CNT_W-1:0] cnt_timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ISSUE   = 2'd2
    } state_t;

    localparam int TMR_W = 10;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t             state_r;
    logic [2:0]         mask_r;
    logic [TMR_W-1:0]   timer_r;
    logic               ap_start_r;
    logic               busy_r;
    logic [PL_W-1:0]    pl_r;
    logic [SF_W-1:0]    inn_r;
    logic [SF_W-1:0]    mid_r;
    logic [SF_W-1:0]    out_r;
    logic [CNT_W-1:0]   drop_r;
    logic [CNT_W-1:0]   orphan_r;
    logic [CNT_W-1:0]   timeout_r;

    logic [2:0]         vld_s;
    logic [2:0]         new_s;
    logic [2:0]         dup_s;
    logic [2:0]         mask_nxt_s;

    function automatic logic [1:0] pop3(input logic [2:0] v);
        pop3 = {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    // Saturating add; an increment that would overflow clamps at all-ones.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, c} + (CNT_W+1)'(inc);
        if (sum[CNT_W]) begin
            sat_add = {CNT_W{1'b1}};
        end else begin
            sat_add = sum[CNT_W-1:0];
        end
    endfunction

    // Strobe classification against the stations already received.
    always_comb begin
        vld_s      = {sf_out_vld, sf_mid_vld, sf_inn_vld};
        new_s      = vld_s & ~mask_r;
        dup_s      = vld_s & mask_r;
        mask_nxt_s = mask_r | vld_s;
    end

    // Main controller: capture, collect, issue and diagnostic counting.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_r    <= IDLE;
            mask_r     <= 3'b000;
            timer_r    <= '0;
            ap_start_r <= 1'b0;
            busy_r     <= 1'b0;
            pl_r       <= '0;
            inn_r      <= '0;
            mid_r      <= '0;
            out_r      <= '0;
            drop_r     <= '0;
            orphan_r   <= '0;
            timeout_r  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pl_in_vld) begin
                        pl_r    <= pl_in;
                        inn_r   <= vld_s[0] ? sf_inn_in : '0;
                        mid_r   <= vld_s[1] ? sf_mid_in : '0;
                        out_r   <= vld_s[2] ? sf_out_in : '0;
                        mask_r  <= vld_s;
                        timer_r <= '0;
                        busy_r  <= 1'b1;
                        state_r <= COLLECT;
                    end else begin
                        orphan_r <= sat_add(orphan_r, pop3(vld_s));
                    end
                end
                COLLECT: begin
                    if (new_s[0]) inn_r <= sf_inn_in;
                    if (new_s[1]) mid_r <= sf_mid_in;
                    if (new_s[2]) out_r <= sf_out_in;
                    mask_r   <= mask_nxt_s;
                    orphan_r <= sat_add(orphan_r, pop3(dup_s));
                    drop_r   <= sat_add(drop_r, {1'b0, pl_in_vld});
                    timer_r  <= timer_r + TMR_W'(1);
                    if (mask_nxt_s == 3'b111) begin
                        ap_start_r <= 1'b1;
                        state_r    <= ISSUE;
                    end else if (timer_r == TMR_LAST) begin
                        if (pop3(mask_nxt_s) >= 2'd2) begin
                            ap_start_r <= 1'b1;
                            state_r    <= ISSUE;
                        end else begin
                            // Too few stations to be useful: discard the whole set.
                            timeout_r <= sat_add(timeout_r, 2'd1);
                            pl_r      <= '0;
                            inn_r     <= '0;
                            mid_r     <= '0;
                            out_r     <= '0;
                            mask_r    <= 3'b000;
                            busy_r    <= 1'b0;
                            state_r   <= IDLE;
                        end
                    end
                end
                ISSUE: begin
                    orphan_r <= sat_add(orphan_r, pop3(vld_s));
                    drop_r   <= sat_add(drop_r, {1'b0, pl_in_vld});
                    if (ap_ready) begin
                        ap_start_r <= 1'b0;
                        busy_r     <= 1'b0;
                        state_r    <= IDLE;
                    end
                end
                default: begin
                    ap_start_r <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    assign ap_start      = ap_start_r;
    assign busy          = busy_r;
    assign pl2ptcalc     = pl_r;
    assign sf2ptcalc_inn = inn_r;
    assign sf2ptcalc_mid = mid_r;
    assign sf2ptcalc_out = out_r;
    assign cnt_pl_drop   = drop_r;
    assign cnt_sf_orphan = orphan_r;
    assign cnt_timeout   = timeout_r;

endmodule

// File: tb/tb_ptcalc_in_sync.sv
// Scoreboard bench for ptcalc_in_sync: expected issued sets are queued at stimulus time
// and compared when ap_start is seen; counters are tracked by a saturating model.
module tb_ptcalc_in_sync;

    localparam int PL_W    = 64;
    localparam int SF_W    = 32;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 4;

    logic             ap_clk = 1'b0;
    logic             ap_rst;
    logic [PL_W-1:0]  pl_in;
    logic             pl_in_vld;
    logic [SF_W-1:0]  sf_inn_in, sf_mid_in, sf_out_in;
    logic             sf_inn_vld, sf_mid_vld, sf_out_vld;
    logic             ap_start;
    logic             ap_ready;
    logic [PL_W-1:0]  pl2ptcalc;
    logic [SF_W-1:0]  sf2ptcalc_inn, sf2ptcalc_mid, sf2ptcalc_out;
    logic             busy;
    logic [CNT_W-1:0] cnt_pl_drop, cnt_sf_orphan, cnt_timeout;

    typedef struct packed {
        logic [PL_W-1:0] pl;
        logic [SF_W-1:0] inn;
        logic [SF_W-1:0] mid;
        logic [SF_W-1:0] out;
    } set_t;

    set_t sb_q[$];
    set_t act;
    assign act = {pl2ptcalc, sf2ptcalc_inn, sf2ptcalc_mid, sf2ptcalc_out};

    int checks = 0;
    int errors = 0;
    logic [CNT_W-1:0] e_drop, e_orph, e_to;

    always #5 ap_clk = ~ap_clk;

    ptcalc_in_sync #(.PL_W(PL_W), .SF_W(SF_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .pl_in(pl_in), .pl_in_vld(pl_in_vld),
        .sf_inn_in(sf_inn_in), .sf_mid_in(sf_mid_in), .sf_out_in(sf_out_in),
        .sf_inn_vld(sf_inn_vld), .sf_mid_vld(sf_mid_vld), .sf_out_vld(sf_out_vld),
        .ap_start(ap_start), .ap_ready(ap_ready),
        .pl2ptcalc(pl2ptcalc),
        .sf2ptcalc_inn(sf2ptcalc_inn), .sf2ptcalc_mid(sf2ptcalc_mid), .sf2ptcalc_out(sf2ptcalc_out),
        .busy(busy),
        .cnt_pl_drop(cnt_pl_drop), .cnt_sf_orphan(cnt_sf_orphan), .cnt_timeout(cnt_timeout)
    );

    function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] c, input int inc);
        int s;
        s = int'(c) + inc;
        if (s > (1 << CNT_W) - 1) return {CNT_W{1'b1}};
        return s[CNT_W-1:0];
    endfunction

    task automatic tick;
        @(posedge ap_clk);
        #1;
    endtask

    // One cycle of strobes; sv = {out, mid, inn}.
    task automatic pulse(input logic pv, input logic [PL_W-1:0] p, input logic [2:0] sv,
                         input logic [SF_W-1:0] i, input logic [SF_W-1:0] m, input logic [SF_W-1:0] o);
        pl_in = p; pl_in_vld = pv;
        sf_inn_in = i; sf_mid_in = m; sf_out_in = o;
        sf_inn_vld = sv[0]; sf_mid_vld = sv[1]; sf_out_vld = sv[2];
        tick();
        pl_in_vld = 1'b0; sf_inn_vld = 1'b0; sf_mid_vld = 1'b0; sf_out_vld = 1'b0;
    endtask

    task automatic test_reset;
        ap_rst = 1'b1;
        pulse(1'b1, 64'hFFFF_0000_FFFF_0000, 3'b111, 32'h5, 32'h6, 32'h7);
        tick();
        ap_rst = 1'b0;
        e_drop = '0; e_orph = '0; e_to = '0;
        checks++;
        if ({ap_start, busy} !== 2'b00) begin
            errors++; $display("FAIL reset_ctrl: got %b want 00", {ap_start, busy});
        end
        checks++;
        if (act !== '0) begin
            errors++; $display("FAIL reset_data: got %h want 0", act);
        end
        checks++;
        if ({cnt_pl_drop, cnt_sf_orphan, cnt_timeout} !== {e_drop, e_orph, e_to}) begin
            errors++; $display("FAIL reset_cnt: got %h want %h", {cnt_pl_drop, cnt_sf_orphan, cnt_timeout}, {e_drop, e_orph, e_to});
        end
    endtask

    task automatic test_full_set;
        set_t e;
        e = '{pl: 64'hA5A5_A5A5_A5A5_A5A5, inn: 32'd1, mid: 32'd2, out: 32'd3};
        sb_q.push_back(e);
        pulse(1'b1, e.pl, 3'b111, e.inn, e.mid, e.out);
        checks++;
        if ({ap_start, busy} !== 2'b01) begin
            errors++; $display("FAIL full_edge1: got %b want 01", {ap_start, busy});
        end
        tick();
        checks++;
        if (ap_start !== 1'b1) begin
            errors++; $display("FAIL full_start: got %b want 1", ap_start);
        end
        e = sb_q.pop_front();
        checks++;
        if (act !== e) begin
            errors++; $display("FAIL full_data: got %h want %h", act, e);
        end
        ap_ready = 1'b1;
        tick();
        ap_ready = 1'b0;
        checks++;
        if ({ap_start, busy} !== 2'b00) begin
            errors++; $display("FAIL full_done: got %b want 00", {ap_start, busy});
        end
        checks++;
        if ({cnt_pl_drop, cnt_sf_orphan, cnt_timeout} !== {e_drop, e_orph, e_to}) begin
            errors++; $display("FAIL full_cnt: got %h want %h", {cnt_pl_drop, cnt_sf_orphan, cnt_timeout}, {e_drop, e_orph, e_to});
        end
    endtask

    task automatic test_staggered;
        set_t e;
        e = '{pl: 64'h1234_5678_9ABC_DEF0, inn: 32'h11, mid: 32'h22, out: 32'h33};
        sb_q.push_back(e);
        ap_ready = 1'b1;
        pulse(1'b1, e.pl, 3'b000, '0, '0, '0);
        tick(); tick();
        ap_ready = 1'b0;
        pulse(1'b0, '0, 3'b001, e.inn, '0, '0);
        tick(); tick(); tick();
        pulse(1'b0, '0, 3'b100, '0, '0, e.out);
        tick(); tick();
        checks++;
        if ({ap_start, busy} !== 2'b01) begin
            errors++; $display("FAIL stag_early: got %b want 01", {ap_start, busy});
        end
        pulse(1'b0, '0, 3'b010, '0, e.mid, '0);
        checks++;
        if (ap_start !== 1'b1) begin
            errors++; $display("FAIL stag_rise: got %b want 1", ap_start);
        end
        e = sb_q.pop_front();
        checks++;
        if (act !== e) begin
            errors++; $display("FAIL stag_data: got %h want %h", act, e);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (ap_start !== 1'b1 || act !== e) begin
                errors++; $display("FAIL stag_hold%0d: got %b/%h want 1/%h", k, ap_start, act, e);
            end
        end
        ap_ready = 1'b1;
        tick();
        ap_ready = 1'b0;
        checks++;
        if ({ap_start, busy} !== 2'b00 || act !== e) begin
            errors++; $display("FAIL stag_release: got %b/%h want 00/%h", {ap_start, busy}, act, e);
        end
    endtask

    task automatic test_timeout;
        set_t e;
        e = '{pl: 64'hCAFE_0000_1111_2222, inn: 32'hAAAA, mid: 32'hBBBB, out: 32'h0};
        sb_q.push_back(e);
        pulse(1'b1, e.pl, 3'b000, '0, '0, '0);
        pulse(1'b0, '0, 3'b001, e.inn, '0, '0);
        pulse(1'b0, '0, 3'b010, '0, e.mid, '0);
        for (int k = 3; k < TIMEOUT; k++) tick();
        checks++;
        if ({ap_start, busy} !== 2'b01) begin
            errors++; $display("FAIL part_before: got %b want 01", {ap_start, busy});
        end
        tick();
        checks++;
        if (ap_start !== 1'b1) begin
            errors++; $display("FAIL part_start: got %b want 1", ap_start);
        end
        e = sb_q.pop_front();
        checks++;
        if (act !== e) begin
            errors++; $display("FAIL part_data: got %h want %h", act, e);
        end
        ap_ready = 1'b1;
        tick();
        ap_ready = 1'b0;

        pulse(1'b1, 64'h7777_8888_9999_AAAA, 3'b000, '0, '0, '0);
        pulse(1'b0, '0, 3'b001, 32'h4444, '0, '0);
        for (int k = 2; k < TIMEOUT; k++) tick();
        checks++;
        if ({ap_start, busy} !== 2'b01) begin
            errors++; $display("FAIL drop_before: got %b want 01", {ap_start, busy});
        end
        tick();
        e_to = sat(e_to, 1);
        checks++;
        if ({ap_start, busy} !== 2'b00 || act !== '0) begin
            errors++; $display("FAIL drop_idle: got %b/%h want 00/0", {ap_start, busy}, act);
        end
        checks++;
        if ({cnt_pl_drop, cnt_sf_orphan, cnt_timeout} !== {e_drop, e_orph, e_to}) begin
            errors++; $display("FAIL drop_cnt: got %h want %h", {cnt_pl_drop, cnt_sf_orphan, cnt_timeout}, {e_drop, e_orph, e_to});
        end
    endtask

    task automatic test_busy_drops;
        set_t e;
        e = '{pl: 64'h0BAD_F00D_0000_0001, inn: 32'h100, mid: 32'h200, out: 32'h300};
        sb_q.push_back(e);
        pulse(1'b1, e.pl, 3'b000, '0, '0, '0);
        pulse(1'b0, '0, 3'b010, '0, e.mid, '0);
        pulse(1'b1, 64'hDEAD, 3'b000, '0, '0, '0);
        e_drop = sat(e_drop, 1);
        pulse(1'b0, '0, 3'b010, '0, 32'h999, '0);
        e_orph = sat(e_orph, 1);
        pulse(1'b0, '0, 3'b101, e.inn, '0, e.out);
        checks++;
        if (ap_start !== 1'b1) begin
            errors++; $display("FAIL busy_start: got %b want 1", ap_start);
        end
        e = sb_q.pop_front();
        pulse(1'b1, 64'hBEEF, 3'b000, '0, '0, '0);
        e_drop = sat(e_drop, 1);
        checks++;
        if (ap_start !== 1'b1 || act !== e) begin
            errors++; $display("FAIL busy_issue: got %b/%h want 1/%h", ap_start, act, e);
        end
        ap_ready = 1'b1;
        tick();
        ap_ready = 1'b0;
        checks++;
        if ({ap_start, busy} !== 2'b00 || act !== e) begin
            errors++; $display("FAIL busy_done: got %b/%h want 00/%h", {ap_start, busy}, act, e);
        end
        checks++;
        if ({cnt_pl_drop, cnt_sf_orphan, cnt_timeout} !== {e_drop, e_orph, e_to}) begin
            errors++; $display("FAIL busy_cnt: got %h want %h", {cnt_pl_drop, cnt_sf_orphan, cnt_timeout}, {e_drop, e_orph, e_to});
        end
        pulse(1'b0, '0, 3'b111, 32'h1, 32'h2, 32'h3);
        e_orph = sat(e_orph, 3);
        checks++;
        if (busy !== 1'b0 || {cnt_pl_drop, cnt_sf_orphan, cnt_timeout} !== {e_drop, e_orph, e_to}) begin
            errors++; $display("FAIL idle_orphan: got %b/%h want 0/%h", busy, {cnt_pl_drop, cnt_sf_orphan, cnt_timeout}, {e_drop, e_orph, e_to});
        end
    endtask

    task automatic test_saturation;
        for (int k = 0; k < 10; k++) begin
            pulse(1'b0, '0, 3'b001, 32'h1, '0, '0);
            e_orph = sat(e_orph, 1);
        end
        checks++;
        if (cnt_sf_orphan !== e_orph) begin
            errors++; $display("FAIL sat_mid: got %0d want %0d", cnt_sf_orphan, e_orph);
        end
        pulse(1'b0, '0, 3'b111, '0, '0, '0);
        e_orph = sat(e_orph, 3);
        checks++;
        if (cnt_sf_orphan !== 4'd15 || e_orph !== 4'd15) begin
            errors++; $display("FAIL sat_clamp3: got %0d want 15", cnt_sf_orphan);
        end
        for (int k = 0; k < 10; k++) begin
            pulse(1'b0, '0, 3'b001, 32'h1, '0, '0);
            e_orph = sat(e_orph, 1);
        end
        pulse(1'b0, '0, 3'b111, '0, '0, '0);
        e_orph = sat(e_orph, 3);
        checks++;
        if (cnt_sf_orphan !== e_orph || busy !== 1'b0) begin
            errors++; $display("FAIL sat_stay: got %0d/%b want %0d/0", cnt_sf_orphan, busy, e_orph);
        end
    endtask

    task automatic test_reset_mid_issue;
        set_t e;
        int n;
        pulse(1'b1, 64'h5555_AAAA_5555_AAAA, 3'b111, 32'h9, 32'h8, 32'h7);
        tick(); tick();
        checks++;
        if (ap_start !== 1'b1) begin
            errors++; $display("FAIL rst_pre: got %b want 1", ap_start);
        end
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        e_drop = '0; e_orph = '0; e_to = '0;
        checks++;
        if ({ap_start, busy} !== 2'b00 || act !== '0) begin
            errors++; $display("FAIL rst_mid: got %b/%h want 00/0", {ap_start, busy}, act);
        end
        checks++;
        if ({cnt_pl_drop, cnt_sf_orphan, cnt_timeout} !== {e_drop, e_orph, e_to}) begin
            errors++; $display("FAIL rst_cnt: got %h want %h", {cnt_pl_drop, cnt_sf_orphan, cnt_timeout}, {e_drop, e_orph, e_to});
        end
        e = '{pl: 64'h0123_4567_89AB_CDEF, inn: 32'hC1, mid: 32'hC2, out: 32'hC3};
        sb_q.push_back(e);
        pulse(1'b1, e.pl, 3'b111, e.inn, e.mid, e.out);
        n = 0;
        while (ap_start !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        checks++;
        if (ap_start !== 1'b1 || n != 1) begin
            errors++; $display("FAIL rst_recover: got start=%b after %0d cycles want 1 after 1", ap_start, n);
        end
        e = sb_q.pop_front();
        checks++;
        if (act !== e) begin
            errors++; $display("FAIL rst_recover_data: got %h want %h", act, e);
        end
        ap_ready = 1'b1;
        tick();
        ap_ready = 1'b0;
        checks++;
        if ({ap_start, busy} !== 2'b00 || sb_q.size() != 0) begin
            errors++; $display("FAIL rst_recover_done: got %b/%0d want 00/0", {ap_start, busy}, sb_q.size());
        end
    endtask

    initial begin
        ap_rst = 1'b1; ap_ready = 1'b0;
        pl_in = '0; pl_in_vld = 1'b0;
        sf_inn_in = '0; sf_mid_in = '0; sf_out_in = '0;
        sf_inn_vld = 1'b0; sf_mid_vld = 1'b0; sf_out_vld = 1'b0;
        test_reset();
        test_full_set();
        test_staggered();
        test_timeout();
        test_busy_drops();
        test_saturation();
        test_reset_mid_issue();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
